shared_mem_arbiter: RTL and testbench

Parametrised multi-port shared memory for the CPU system: `NUM_PORTS` requesters (instruction fetch, data load/store, future DMA) reach one word-organised storage array through a round-robin arbiter. Each port uses a valid/ready request handshake and receives a registered one-cycle response. It replaces the fixed two-port memory hookup at system top level with a generalised, arbitrated, width- and depth-configurable block.

---
 rtl/shared_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_shared_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: NUM_PORTS requesters share one word-organised storage
// array through a single-access-per-cycle arbiter. Each accepted transfer is
// answered two edges later with a one-cycle rsp_valid pulse on its own port.
// Build option: define SHARED_MEM_FIXED_PRIO_EN for fixed lowest-index-wins
// priority (no pointer register); default is round-robin arbitration.
module shared_mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTES  = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int OFF_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 0;
    localparam int WORDS          = NUM_BYTES / BYTES_PER_WORD;
    localparam int IDX_W          = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PORT_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]             grant;
    logic                             xfer;
    logic [PORT_W-1:0]                sel_port;
    logic                             sel_write;
    logic [ADDR_WIDTH-1:0]            sel_addr;
    logic [DATA_WIDTH-1:0]            sel_wdata;
    logic [ADDR_WIDTH-1:0]            word_addr;
    logic [IDX_W-1:0]                 widx;
    logic                             unused_addr;

    logic [DATA_WIDTH-1:0]            mem_q [WORDS];
    logic                             pend_vld_q;
    logic [PORT_W-1:0]                pend_port_q;
    logic [DATA_WIDTH-1:0]            pend_data_q;
    logic [NUM_PORTS-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;

`ifdef SHARED_MEM_FIXED_PRIO_EN
    // Fixed priority: the lowest-indexed valid port always wins.
    always_comb begin
        grant = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`else
    logic [PORT_W-1:0] ptr_q, ptr_d;

    // Round-robin: search starts one past the last granted port.
    always_comb begin
        logic              found;
        logic [PORT_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = PORT_W'((int'(ptr_q) + k) % NUM_PORTS);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign ptr_d = xfer ? sel_port : ptr_q;

    // Pointer remembers the last accepted port; reset makes port 0 win first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= PORT_W'(NUM_PORTS - 1);
        else        ptr_q <= ptr_d;
    end
`endif

    // No grant can leave the block while reset is held.
    assign req_ready = reset ? grant : '0;
    assign xfer      = |req_ready;

    // Route the winning port's command onto the single storage access path.
    always_comb begin
        sel_port  = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_port  = PORT_W'(i);
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Byte-offset bits are dropped and address bits above the array wrap.
    assign word_addr   = sel_addr >> OFF_W;
    assign widx        = (WORDS > 1) ? word_addr[IDX_W-1:0] : '0;
    assign unused_addr = ^word_addr;

    // Storage array: writes land at the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < WORDS; w++) mem_q[w] <= '0;
        end else if (xfer && sel_write) begin
            mem_q[widx] <= sel_wdata;
        end
    end

    // Accepted transfer held one cycle; a reset here drops it unanswered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_vld_q  <= 1'b0;
            pend_port_q <= '0;
            pend_data_q <= '0;
        end else begin
            pend_vld_q  <= xfer;
            pend_port_q <= sel_port;
            pend_data_q <= sel_write ? sel_wdata : mem_q[widx];
        end
    end

    // Response next state: pulse the owning port, other slices keep their data.
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (pend_vld_q) begin
            rsp_valid_d[pend_port_q] = 1'b1;
            rsp_rdata_d[pend_port_q*DATA_WIDTH +: DATA_WIDTH] = pend_data_q;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter (3 ports, 32-bit words, 64 bytes). A rule-level
// model predicts grants and responses; pinned literals anchor key cycles.
module tb_shared_mem_arbiter;

    localparam int NP    = 3;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int NB    = 64;
    localparam int WORDS = NB / (DW / 8);
    localparam logic [31:0] D1 = 32'h5A5A_1111;
    localparam logic [31:0] D2 = 32'h0BAD_C0DE;

    logic                clk = 1'b0;
    logic                reset;
    logic [NP-1:0]       req_valid, req_ready, req_write, rsp_valid;
    logic [NP*AW-1:0]    req_addr;
    logic [NP*DW-1:0]    req_wdata, rsp_rdata;

    always #5 clk = ~clk;

    shared_mem_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTES(NB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    int total = 0;
    int bad   = 0;

    // pinned hand-computed expectations for the current cycle (-1 = none)
    int          pin_rdy   = -1;
    int          pin_vld   = -1;
    int          pin_dport = -1;
    logic [31:0] pin_dval  = '0;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [WORDS];
    int            m_last;
    logic          m_due_vld;
    int            m_due_port;
    logic [DW-1:0] m_due_data;
    logic [NP-1:0] m_exp_vld;
    logic [DW-1:0] m_exp_data [NP];

    int            m_win;
    logic          m_w_write;
    logic [AW-1:0] m_w_addr;
    logic [DW-1:0] m_w_wdata;
    int            m_w_word;

    function automatic int pick(input logic [NP-1:0] v, input int last);
`ifdef SHARED_MEM_FIXED_PRIO_EN
        for (int i = 0; i < NP; i++) if (v[2'(i)]) return i;
        if (last < -1) return -1;
`else
        for (int k = 1; k <= NP; k++) begin
            int idx;
            idx = (last + k) % NP;
            if (v[2'(idx)]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic logic [NP-1:0] onehot(input int i);
        logic [NP-1:0] r;
        r = '0;
        if (i >= 0) r[2'(i)] = 1'b1;
        return r;
    endfunction

    always_comb begin
        m_win     = reset ? pick(req_valid, m_last) : -1;
        m_w_write = 1'b0;
        m_w_addr  = '0;
        m_w_wdata = '0;
        if (m_win >= 0) begin
            m_w_write = req_write[2'(m_win)];
            m_w_addr  = req_addr[m_win*AW +: AW];
            m_w_wdata = req_wdata[m_win*DW +: DW];
        end
        m_w_word = int'((m_w_addr / 32'd4) % WORDS);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < WORDS; w++) m_mem[w] <= '0;
            for (int p = 0; p < NP; p++) m_exp_data[p] <= '0;
            m_last     <= NP - 1;
            m_due_vld  <= 1'b0;
            m_due_port <= 0;
            m_due_data <= '0;
            m_exp_vld  <= '0;
        end else begin
            m_exp_vld <= m_due_vld ? onehot(m_due_port) : '0;
            if (m_due_vld) m_exp_data[m_due_port] <= m_due_data;
            m_due_vld <= (m_win >= 0);
            if (m_win >= 0) begin
                m_last     <= m_win;
                m_due_port <= m_win;
                m_due_data <= m_w_write ? m_w_wdata : m_mem[m_w_word];
                if (m_w_write) m_mem[m_w_word] <= m_w_wdata;
            end
        end
    end

    // ---------------- compare process ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("ready", DW'(req_ready), DW'(onehot(m_win)));
        check("rsp_valid", DW'(rsp_valid), DW'(m_exp_vld));
        for (int p = 0; p < NP; p++)
            check($sformatf("rdata%0d", p), rsp_rdata[p*DW +: DW], m_exp_data[p]);
        if (pin_rdy >= 0)   check("pin_ready", DW'(req_ready), DW'(pin_rdy));
        if (pin_vld >= 0)   check("pin_rsp_valid", DW'(rsp_valid), DW'(pin_vld));
        if (pin_dport >= 0) check("pin_rdata", rsp_rdata[pin_dport*DW +: DW], pin_dval);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic [NP-1:0] v, input logic [NP-1:0] w,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] a2,
                        input int erdy, input int evld, input int dport,
                        input logic [31:0] dval);
        reset     = rst;
        req_valid = v;
        req_write = w;
        req_addr  = {a2, a1, a0};
        req_wdata = {D2, D1, d0};
        pin_rdy   = erdy;
        pin_vld   = evld;
        pin_dport = dport;
        pin_dval  = dval;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        #1;
        // reset held with all ports requesting
        step(0, 3'b111, 3'b000, 0, 0, 0, 0,                  0, 0,  0, 32'h0);
        step(0, 3'b111, 3'b000, 0, 0, 0, 0,                  0, 0,  0, 32'h0);
        // read 0x0 after release
        step(1, 3'b001, 3'b000, 0, 0, 0, 0,                  1, 0, -1, 32'h0);
        step(1, 3'b000, 3'b000, 0, 0, 0, 0,                  0, 0, -1, 32'h0);
        // write 0x8 then read 0x8
        step(1, 3'b001, 3'b001, 32'h8, 32'hDEADBEEF, 0, 0,   1, 1,  0, 32'h0);
        step(1, 3'b001, 3'b000, 32'h8, 0, 0, 0,              1, 0, -1, 32'h0);
        // wrap: write 0x44, read 0x04 and 0x05
        step(1, 3'b001, 3'b001, 32'h44, 32'h12345678, 0, 0,  1, 1,  0, 32'hDEADBEEF);
        step(1, 3'b001, 3'b000, 32'h4, 0, 0, 0,              1, 1,  0, 32'hDEADBEEF);
        step(1, 3'b001, 3'b000, 32'h5, 0, 0, 0,              1, 1,  0, 32'h12345678);
        step(1, 3'b000, 3'b000, 0, 0, 0, 0,                  0, 1,  0, 32'h12345678);
        step(1, 3'b000, 3'b000, 0, 0, 0, 0,                  0, 1,  0, 32'h12345678);
        // fresh reset clears storage and responses
        step(0, 3'b111, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 0,  0, 32'h0);
`ifndef SHARED_MEM_FIXED_PRIO_EN
        // all ports valid from reset: 0,1,2,0,1,2 (port 2 writes 0x10)
        step(1, 3'b111, 3'b100, 32'h8, 0, 32'h10, 32'h10,    1, 0, -1, 32'h0);
        step(1, 3'b111, 3'b100, 32'h8, 0, 32'h10, 32'h10,    2, 0, -1, 32'h0);
        step(1, 3'b111, 3'b100, 32'h8, 0, 32'h10, 32'h10,    4, 1,  0, 32'h0);
        step(1, 3'b111, 3'b100, 32'h8, 0, 32'h10, 32'h10,    1, 2,  1, 32'h0);
        step(1, 3'b111, 3'b100, 32'h8, 0, 32'h10, 32'h10,    2, 4,  2, D2);
        step(1, 3'b111, 3'b100, 32'h8, 0, 32'h10, 32'h10,    4, 1,  0, 32'h0);
        step(1, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 2,  1, D2);
        // port 1 read accepted, then reset before its response
        step(1, 3'b010, 3'b000, 32'h8, 0, 32'h10, 32'h10,    2, 4,  2, D2);
`else
        // ports 0 and 1 held valid for 4 cycles: port 0 always wins
        step(1, 3'b011, 3'b000, 32'h8, 0, 32'h10, 32'h10,    1, 0, -1, 32'h0);
        step(1, 3'b011, 3'b000, 32'h8, 0, 32'h10, 32'h10,    1, 0, -1, 32'h0);
        step(1, 3'b011, 3'b000, 32'h8, 0, 32'h10, 32'h10,    1, 1,  0, 32'h0);
        step(1, 3'b011, 3'b000, 32'h8, 0, 32'h10, 32'h10,    1, 1,  0, 32'h0);
        step(1, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 1,  0, 32'h0);
        step(1, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 1,  0, 32'h0);
        step(1, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 0, -1, 32'h0);
        // port 1 read accepted, then reset before its response
        step(1, 3'b010, 3'b000, 32'h8, 0, 32'h10, 32'h10,    2, 0, -1, 32'h0);
`endif
        step(0, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 0,  1, 32'h0);
        step(0, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 0,  1, 32'h0);
        // after release port 0 wins first
        step(1, 3'b011, 3'b000, 32'h8, 0, 32'h10, 32'h10,    1, 0, -1, 32'h0);
`ifndef SHARED_MEM_FIXED_PRIO_EN
        step(1, 3'b011, 3'b000, 32'h8, 0, 32'h10, 32'h10,    2, 0, -1, 32'h0);
        step(1, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 1,  0, 32'h0);
        step(1, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 2,  1, 32'h0);
`else
        step(1, 3'b011, 3'b000, 32'h8, 0, 32'h10, 32'h10,    1, 0, -1, 32'h0);
        step(1, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 1,  0, 32'h0);
        step(1, 3'b000, 3'b000, 32'h8, 0, 32'h10, 32'h10,    0, 1,  0, 32'h0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
